daisy_axi_rd_arb: RTL and testbench

Round-robin arbiter that shares the single 128-bit AXI read channel (AR/R) of the DAISY subsystem between NREQ internal read requesters. It registers the winning request onto AR, tags ARID with the requester index, routes returning R beats back by RID, and caps outstanding bursts per requester. It sits between the DAISY requester engines and the AXI master port driven into the `TH` interconnect.

---
 rtl/daisy_axi_rd_arb_if.sv | 33 +++
 rtl/daisy_axi_rd_arb.sv | 147 ++++++++++++++
 tb/tb_daisy_axi_rd_arb.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/daisy_axi_rd_arb_if.sv
// Bundle of the requester-side and AXI read-channel signals around daisy_axi_rd_arb.
// The arbiter takes the master modport; the requesters and AXI slave side take the slave modport.
interface daisy_axi_rd_arb_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]      req_arvalid;
  logic [NREQ*32-1:0]   req_araddr;
  logic [NREQ*6-1:0]    req_arlen;
  logic [NREQ-1:0]      req_arready;
  logic                 arvalid;
  logic                 arready;
  logic [3:0]           arid;
  logic [31:0]          araddr;
  logic [5:0]           arlen;
  logic [2:0]           arsize;
  logic [1:0]           arburst;
  logic                 rvalid;
  logic                 rready;
  logic [3:0]           rid;
  logic                 rlast;
  logic [NREQ-1:0]      req_rvalid;
  logic [NREQ-1:0]      req_rready;

  modport master (
    input  req_arvalid, req_araddr, req_arlen, arready, rvalid, rid, rlast, req_rready,
    output req_arready, arvalid, arid, araddr, arlen, arsize, arburst, rready, req_rvalid
  );

  modport slave (
    output req_arvalid, req_araddr, req_arlen, arready, rvalid, rid, rlast, req_rready,
    input  req_arready, arvalid, arid, araddr, arlen, arsize, arburst, rready, req_rvalid
  );
endinterface

// File: rtl/daisy_axi_rd_arb.sv
// Round-robin arbiter sharing one AXI read channel between NREQ requesters, with per-requester
// outstanding-burst caps and RID-based R routing. Define DAISY_RD_ARB_FIXED_PRIO_EN for fixed priority.
module daisy_axi_rd_arb #(
  parameter int NREQ     = 4,
  parameter int MAX_OUTS = 4
) (
  input  logic                aclk,
  input  logic                arest,
  daisy_axi_rd_arb_if.master  bus,
  output logic                err_badid
);

  localparam int                OUTS_W   = $clog2(MAX_OUTS + 1);
  localparam logic [OUTS_W-1:0] OUTS_MAX = OUTS_W'(MAX_OUTS);
  localparam logic [4:0]        NREQ5    = 5'(NREQ);
  localparam logic [3:0]        LAST_ID  = 4'(NREQ - 1);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t            state;
  logic [3:0]        ptr;
  logic [3:0]        ar_id;
  logic [31:0]       ar_addr;
  logic [5:0]        ar_len;
  logic              ar_valid;
  logic [OUTS_W-1:0] outs [NREQ];

  logic [NREQ-1:0]   elig, rot, gnt, inc, r_hit, r_last;
  logic              any_elig, bad_rid, unmatched, ar_fire;
  logic [4:0]        off, sum;
  logic [3:0]        win;
  logic [31:0]       sel_addr;
  logic [5:0]        sel_len;

  assign bus.arvalid = ar_valid;
  assign bus.arid    = ar_id;
  assign bus.araddr  = ar_addr;
  assign bus.arlen   = ar_len;
  assign bus.arsize  = 3'b100;
  assign bus.arburst = 2'b01;
  assign ar_fire     = (state == ISSUE) && bus.arready;

  // Rotating the eligible set by ptr turns "first at or after ptr" into "lowest set bit".
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    any_elig = 1'b0;
    off      = '0;
    for (int i = 0; i < NREQ; i++) elig[i] = bus.req_arvalid[i] && (outs[i] < OUTS_MAX);
    rot = NREQ'({elig, elig} >> ptr);
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        any_elig = 1'b1;
        off      = 5'(k);
      end
    end
    sum = {1'b0, ptr} + off;
    win = (sum >= NREQ5) ? 4'(sum - NREQ5) : sum[3:0];
  end

  always_comb begin
    gnt      = '0;
    inc      = '0;
    sel_addr = '0;
    sel_len  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == 4'(i)) begin
        sel_addr = bus.req_araddr[32*i +: 32];
        sel_len  = bus.req_arlen[6*i +: 6];
        gnt[i]   = (state == IDLE) && any_elig;
      end
      inc[i] = ar_fire && (ar_id == 4'(i));
    end
  end

  assign bus.req_arready = gnt;

  // Zero-latency R routing; an unknown RID is swallowed so the interconnect never stalls on it.
  always_comb begin
    r_hit     = '0;
    bad_rid   = 1'b1;
    bus.rready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      if (bus.rid == 4'(i)) begin
        r_hit[i]   = 1'b1;
        bad_rid    = 1'b0;
        bus.rready = bus.req_rready[i];
      end
    end
    bus.req_rvalid = r_hit & {NREQ{bus.rvalid}};
    r_last         = bus.req_rvalid & bus.req_rready & {NREQ{bus.rlast}};
    unmatched      = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_last[i] && (outs[i] == '0)) unmatched = 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge arest) begin
    if (arest) begin
      state     <= IDLE;
      ar_valid  <= 1'b0;
      ar_id     <= '0;
      ar_addr   <= '0;
      ar_len    <= '0;
      ptr       <= '0;
      err_badid <= 1'b0;
      // NOTE: the outs array is control state, not storage, so every entry is reset explicitly.
      for (int i = 0; i < NREQ; i++) outs[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      case (state)
        IDLE: begin
          if (any_elig) begin
            ar_valid <= 1'b1;
            ar_id    <= win;
            ar_addr  <= sel_addr;
            ar_len   <= sel_len;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.arready) begin
            ar_valid <= 1'b0;
            state    <= IDLE;
`ifdef DAISY_RD_ARB_FIXED_PRIO_EN
            ptr      <= '0;
`else
            ptr      <= (ar_id == LAST_ID) ? 4'd0 : ar_id + 4'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase

      // An accept and a completion in the same cycle cancel out.
      for (int i = 0; i < NREQ; i++) begin
        if (inc[i] && !r_last[i]) begin
          outs[i] <= outs[i] + 1'b1;
        end else if (!inc[i] && r_last[i] && (outs[i] != '0)) begin
          outs[i] <= outs[i] - 1'b1;
        end
      end

      if ((bus.rvalid && bad_rid) || unmatched) err_badid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_daisy_axi_rd_arb.sv
// Scoreboard bench for daisy_axi_rd_arb: directed stimulus pushes expected AR/R responses,
// negedge monitors pop and compare them.
module tb_daisy_axi_rd_arb;
  localparam int NREQ     = 4;
  localparam int MAX_OUTS = 4;

`ifdef DAISY_RD_ARB_FIXED_PRIO_EN
  localparam int SEQ_IDS [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
  localparam int SEQ_OUTS[4] = '{4, 4, 0, 0};
  localparam int BP_OUTS2    = 1;
`else
  localparam int SEQ_IDS [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  localparam int SEQ_OUTS[4] = '{2, 2, 2, 2};
  localparam int BP_OUTS2    = 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err_badid;

  always #5 clk = ~clk;

  daisy_axi_rd_arb_if #(.NREQ(NREQ)) bus ();

  daisy_axi_rd_arb #(.NREQ(NREQ), .MAX_OUTS(MAX_OUTS)) dut (
    .aclk      (clk),
    .arest     (rst),
    .bus       (bus.master),
    .err_badid (err_badid)
  );

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [5:0]  len;
  } ar_t;

  typedef struct packed {
    logic [NREQ-1:0] vld;
    logic            rdy;
  } r_t;

  ar_t ar_q[$];
  r_t  r_q[$];
  ar_t ar_e;
  r_t  r_e;
  int  n_checks = 0;
  int  n_pass   = 0;
  int  ar_seen  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic flag(input string name);
    n_checks++;
    $display("FAIL %s: event not expected by scoreboard", name);
  endtask

  // AR scoreboard: every accepted address must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst && bus.arvalid && bus.arready) begin
      ar_seen++;
      if (ar_q.size() == 0) begin
        flag("ar_unexpected");
      end else begin
        ar_e = ar_q.pop_front();
        check("ar_txn", {bus.arid, bus.araddr, bus.arlen}, ar_e);
        check("ar_const", {bus.arsize, bus.arburst}, {3'b100, 2'b01});
      end
    end
  end

  // R scoreboard: routing of every presented beat.
  always @(negedge clk) begin
    if (!rst && bus.rvalid) begin
      if (r_q.size() == 0) begin
        flag("r_unexpected");
      end else begin
        r_e = r_q.pop_front();
        check("r_route", {bus.req_rvalid, bus.rready}, r_e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [5:0] l);
    bus.req_araddr[32*i +: 32] = a;
    bus.req_arlen[6*i +: 6]    = l;
  endtask

  task automatic push_ar(input int id, input logic [31:0] a, input logic [5:0] l);
    ar_q.push_back('{id: 4'(id), addr: a, len: l});
  endtask

  task automatic r_beat(input logic [3:0] id, input logic last, input logic [NREQ-1:0] vld,
                        input logic rdy);
    r_q.push_back('{vld: vld, rdy: rdy});
    bus.rvalid = 1'b1;
    bus.rid    = id;
    bus.rlast  = last;
    tick();
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
  endtask

  task automatic wait_ar(input int target, input int budget);
    for (int c = 0; c < budget && ar_seen < target; c++) tick();
    if (ar_seen < target) flag("ar_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.req_arvalid = '0;
    bus.req_araddr  = '0;
    bus.req_arlen   = '0;
    bus.arready     = 1'b0;
    bus.rvalid      = 1'b0;
    bus.rid         = '0;
    bus.rlast       = 1'b0;
    bus.req_rready  = '1;

    // Reset state
    tick();
    check("rst_ar", {bus.arvalid, bus.arid, bus.araddr, bus.arlen}, '0);
    check("rst_gnt_err", {bus.req_arready, err_badid}, '0);
    for (int i = 0; i < NREQ; i++) check("rst_outs", dut.outs[i], 0);
    rst = 1'b0;
    tick();

    // Single request from requester 2
    set_req(2, 32'h1000, 6'd3);
    bus.req_arvalid = 4'b0100;
    bus.arready     = 1'b1;
    push_ar(2, 32'h1000, 6'd3);
    @(negedge clk);
    check("single_grant_T", {bus.req_arready, bus.arvalid}, {4'b0100, 1'b0});
    tick();
    bus.req_arvalid = '0;
    @(negedge clk);
    check("single_issue_T1", {bus.req_arready, bus.arvalid}, {4'b0000, 1'b1});
    tick();
    check("single_outs_up", dut.outs[2], 1);
    bus.req_rready = 4'b1011;
    r_beat(4'd2, 1'b0, 4'b0100, 1'b0);
    bus.req_rready = '1;
    for (int b = 0; b < 4; b++) r_beat(4'd2, b == 3, 4'b0100, 1'b1);
    check("single_outs_down", dut.outs[2], 0);

    // All requesters continuously valid
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 32'h2000 + 32'(i) * 32'h100, 6'(i));
    for (int n = 0; n < 8; n++) push_ar(SEQ_IDS[n], 32'h2000 + 32'(SEQ_IDS[n]) * 32'h100, 6'(SEQ_IDS[n]));
    bus.req_arvalid = '1;
    bus.arready     = 1'b1;
    wait_ar(ar_seen + 8, 40);
    bus.req_arvalid = '0;
    for (int i = 0; i < NREQ; i++) check("seq_outs", dut.outs[i], SEQ_OUTS[i]);

    // Backpressure: fields must hold while arready is low
    set_req(2, 32'h3000, 6'd5);
    bus.arready     = 1'b0;
    bus.req_arvalid = 4'b0100;
    push_ar(2, 32'h3000, 6'd5);
    @(negedge clk);
    check("bp_grant", bus.req_arready, 4'b0100);
    tick();
    set_req(2, 32'h3333, 6'd7);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_stable", {bus.arvalid, bus.arid, bus.araddr, bus.arlen, bus.req_arready},
            {1'b1, 4'd2, 32'h3000, 6'd5, 4'b0000});
      tick();
    end
    bus.arready     = 1'b1;
    bus.req_arvalid = '0;
    tick();
    check("bp_outs", dut.outs[2], BP_OUTS2);

    // Outstanding cap on requester 1
    do_reset();
    set_req(1, 32'h4000, 6'd1);
    for (int n = 0; n < 4; n++) push_ar(1, 32'h4000, 6'd1);
    bus.req_arvalid = 4'b0010;
    wait_ar(ar_seen + 4, 20);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("cap_no_grant", {bus.req_arready, bus.arvalid}, '0);
      tick();
    end
    check("cap_outs_full", dut.outs[1], 4);
    push_ar(1, 32'h4000, 6'd1);
    r_beat(4'd1, 1'b1, 4'b0010, 1'b1);
    @(negedge clk);
    check("cap_regrant", bus.req_arready, 4'b0010);
    tick();
    bus.req_arvalid = '0;
    tick();
    check("cap_outs_refill", dut.outs[1], 4);

    // Bad RID: dropped, ready forced, sticky error
    bus.req_rready = '0;
    r_beat(4'd7, 1'b0, 4'b0000, 1'b1);
    check("badid_set", err_badid, 1);
    tick();
    tick();
    tick();
    check("badid_sticky", err_badid, 1);
    bus.req_rready = '1;

    // Simultaneous accept and rlast for requester 0
    do_reset();
    check("badid_cleared", err_badid, 0);
    set_req(0, 32'h5000, 6'd2);
    push_ar(0, 32'h5000, 6'd2);
    push_ar(0, 32'h5000, 6'd2);
    bus.req_arvalid = 4'b0001;
    wait_ar(ar_seen + 2, 20);
    bus.arready = 1'b0;
    push_ar(0, 32'h5000, 6'd2);
    tick();
    bus.req_arvalid = '0;
    check("sim_outs_before", dut.outs[0], 2);
    bus.arready = 1'b1;
    r_beat(4'd0, 1'b1, 4'b0001, 1'b1);
    check("sim_outs_after", dut.outs[0], 2);

    // Reset in the middle of an ISSUE
    bus.arready = 1'b0;
    set_req(3, 32'h6000, 6'd0);
    bus.req_arvalid = 4'b1000;
    tick();
    bus.req_arvalid = '0;
    check("mid_issue_vld", bus.arvalid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_arvalid", bus.arvalid, 0);
    for (int i = 0; i < NREQ; i++) check("mid_rst_outs", dut.outs[i], 0);
    tick();
    rst = 1'b0;
    r_beat(4'd0, 1'b1, 4'b0001, 1'b1);
    check("stale_rlast_err", err_badid, 1);
    check("stale_rlast_outs", dut.outs[0], 0);

    tick();
    check("ar_q_drained", ar_q.size(), 0);
    check("r_q_drained", r_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
